mailbox_router: RTL and testbench

Parametrised multi-channel successor to the single-byte, toggle-signalled producer/consumer link. `CHANNELS` producers each push `WIDTH`-bit words into a private `DEPTH`-entry FIFO using a valid/ready handshake. A round-robin arbiter drains the FIFOs to a single consumer port. The block sits between producer agents and one consumer. It also drives a legacy edge-toggle strobe so existing toggle-watching consumers keep working.

---
 rtl/mailbox_pkg.sv | 30 +++
 rtl/mailbox_fifo.sv | 51 +++++
 rtl/mailbox_router.sv | 84 ++++++++
 tb/tb_mailbox_router.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mailbox_pkg.sv
// Shared types, reset constants and the round-robin search helper
// for the multi-channel mailbox router.
package mailbox_pkg;

    localparam int MAX_CH = 64;
    localparam int MAX_CW = 6;

    typedef logic [MAX_CW-1:0] chan_t;

    localparam int   RST_PTR    = 0;
    localparam logic RST_LOCK   = 1'b0;
    localparam logic RST_TOGGLE = 1'b0;

    // First set bit of mask at or after ptr, wrapping at n.
    // The descending loop lets the nearest candidate win.
    function automatic chan_t rr_next(
        input chan_t             ptr,
        input logic [MAX_CH-1:0] mask,
        input int                n
    );
        int idx;
        rr_next = ptr;
        for (int k = MAX_CH - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= n) idx = idx - n;
            if (k < n && mask[idx]) rr_next = chan_t'(idx);
        end
    endfunction

endpackage

// File: rtl/mailbox_fifo.sv
// Single-channel circular FIFO; occupancy is tracked by a counter so
// full and empty never depend on pointer equality.
module mailbox_fifo
    import mailbox_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign wr_ok   = wr_en && !full && !reset;
    assign rd_ok   = rd_en && !empty && !reset;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= AW'(RST_PTR);
            rd_ptr <= AW'(RST_PTR);
            level  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            if (wr_ok && !rd_ok) level <= level + 1'b1;
            else if (rd_ok && !wr_ok) level <= level - 1'b1;
        end
    end

endmodule

// File: rtl/mailbox_router.sv
// Round-robin drain of per-channel FIFOs onto one consumer port,
// with grant lock during stalls and a legacy toggle strobe.
module mailbox_router
    import mailbox_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int CHANNELS = 2,
    localparam int CW = $clog2(CHANNELS),
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CHANNELS-1:0]    put_valid,
    input  logic [CHANNELS*WIDTH-1:0] put_data,
    output logic [CHANNELS-1:0]    put_ready,
    output logic                   get_valid,
    output logic [WIDTH-1:0]       get_data,
    output logic [CW-1:0]          get_chan,
    input  logic                   get_ready,
    output logic                   get_toggle,
    output logic [CHANNELS*LW-1:0] level
);

    logic [CHANNELS-1:0] full;
    logic [CHANNELS-1:0] empty;
    logic [CHANNELS-1:0] wr_en;
    logic [CHANNELS-1:0] rd_en;
    logic [WIDTH-1:0]    rd_data [CHANNELS];
    logic [CW-1:0]       rr_ptr;
    logic [CW-1:0]       held;
    logic [CW-1:0]       cand;
    logic [CW-1:0]       grant;
    logic                lock;
    logic                fire;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign put_ready[i] = !reset && !full[i];
        assign wr_en[i]     = put_valid[i] && put_ready[i];
        assign rd_en[i]     = fire && (grant == CW'(i));

        mailbox_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr_en[i]),
            .wr_data (put_data[i*WIDTH +: WIDTH]),
            .rd_en   (rd_en[i]),
            .rd_data (rd_data[i]),
            .level   (level[i*LW +: LW]),
            .full    (full[i]),
            .empty   (empty[i])
        );
    end

    // A held grant keeps the presented word stable across a stall.
    always_comb begin
        cand      = CW'(rr_next(chan_t'(rr_ptr), MAX_CH'(~empty), CHANNELS));
        grant     = lock ? held : cand;
        get_valid = lock || (|(~empty));
        get_chan  = get_valid ? grant : '0;
        get_data  = get_valid ? rd_data[grant] : '0;
        fire      = get_valid && get_ready && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr     <= CW'(RST_PTR);
            held       <= CW'(RST_PTR);
            lock       <= RST_LOCK;
            get_toggle <= RST_TOGGLE;
        end else if (fire) begin
            lock       <= 1'b0;
            get_toggle <= ~get_toggle;
            rr_ptr     <= (grant == CW'(CHANNELS - 1)) ? '0 : grant + 1'b1;
        end else if (get_valid) begin
            lock <= 1'b1;
            held <= grant;
        end
    end

endmodule

// File: tb/tb_mailbox_router.sv
// Scenario bench for mailbox_router: per-channel scoreboards fed at put
// time and drained by a consumer-side monitor, plus inline scenario checks.
module tb_mailbox_router;

    localparam int WIDTH    = 8;
    localparam int DEPTH    = 4;
    localparam int CHANNELS = 2;
    localparam int CW       = 1;
    localparam int LW       = 3;

    logic                      clk;
    logic                      reset;
    logic [CHANNELS-1:0]       put_valid;
    logic [CHANNELS*WIDTH-1:0] put_data;
    logic [CHANNELS-1:0]       put_ready;
    logic                      get_valid;
    logic [WIDTH-1:0]          get_data;
    logic [CW-1:0]             get_chan;
    logic                      get_ready;
    logic                      get_toggle;
    logic [CHANNELS*LW-1:0]    level;

    int checks;
    int errors;
    logic exp_tog;
    logic [7:0] sb0 [$];
    logic [7:0] sb1 [$];

    mailbox_router #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .CHANNELS (CHANNELS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .put_valid  (put_valid),
        .put_data   (put_data),
        .put_ready  (put_ready),
        .get_valid  (get_valid),
        .get_data   (get_data),
        .get_chan   (get_chan),
        .get_ready  (get_ready),
        .get_toggle (get_toggle),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Consumer-side monitor: pops the source channel's queue on each get.
    always @(negedge clk) begin
        logic [7:0] want;
        if (reset) begin
            exp_tog = 1'b0;
        end else begin
            checks++;
            if (get_toggle !== exp_tog) begin
                errors++;
                $display("FAIL toggle got %b want %b", get_toggle, exp_tog);
            end
            if (get_valid && get_ready) begin
                exp_tog = ~exp_tog;
                checks++;
                if (get_chan === 1'b0 && sb0.size() > 0) begin
                    want = sb0.pop_front();
                    if (get_data !== want) begin
                        errors++;
                        $display("FAIL get_data ch0 got %h want %h", get_data, want);
                    end
                end else if (get_chan === 1'b1 && sb1.size() > 0) begin
                    want = sb1.pop_front();
                    if (get_data !== want) begin
                        errors++;
                        $display("FAIL get_data ch1 got %h want %h", get_data, want);
                    end
                end else begin
                    errors++;
                    $display("FAIL unexpected get chan %0d data %h", get_chan, get_data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        put_valid = 2'b11;
        put_data  = 16'hBEEF;
        get_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        checks += 3;
        if (put_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_put_ready got %b want 00", put_ready);
        end
        if (get_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_get_valid got %b want 0", get_valid);
        end
        if (level !== '0) begin
            errors++;
            $display("FAIL reset_level got %h want 0", level);
        end
        tick();
        reset     = 1'b0;
        put_valid = 2'b00;
        @(negedge clk);
        checks += 3;
        if (put_ready !== 2'b11) begin
            errors++;
            $display("FAIL release_put_ready got %b want 11", put_ready);
        end
        if (get_toggle !== 1'b0) begin
            errors++;
            $display("FAIL release_toggle got %b want 0", get_toggle);
        end
        if (get_chan !== 1'b0 || get_data !== 8'h00) begin
            errors++;
            $display("FAIL release_idle got chan %0d data %h want 0 00", get_chan, get_data);
        end
        tick();
    endtask

    task automatic test_single();
        get_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            put_valid     = (c < 3) ? 2'b01 : 2'b00;
            put_data[7:0] = 8'(c + 1);
            @(negedge clk);
            checks++;
            if (get_valid !== (c > 0)) begin
                errors++;
                $display("FAIL single_latency c=%0d got valid %b want %b", c, get_valid, c > 0);
            end
            if (c < 3) sb0.push_back(8'(c + 1));
            tick();
        end
        put_valid = 2'b00;
        @(negedge clk);
        checks += 2;
        if (get_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drained got valid %b want 0", get_valid);
        end
        if (get_toggle !== 1'b1) begin
            errors++;
            $display("FAIL single_toggle got %b want 1", get_toggle);
        end
        tick();
    endtask

    task automatic test_fill_wrap();
        logic [7:0] v;
        int n;
        v = 8'd10;
        n = 0;
        put_valid = 2'b10;
        get_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            put_data[15:8] = v;
            @(negedge clk);
            checks += 2;
            if (put_ready[1] !== (n < 4)) begin
                errors++;
                $display("FAIL fill_ready c=%0d got %b want %b", c, put_ready[1], n < 4);
            end
            if (level[5:3] !== 3'(n)) begin
                errors++;
                $display("FAIL fill_level c=%0d got %0d want %0d", c, level[5:3], n);
            end
            if (put_ready[1]) begin
                sb1.push_back(v);
                v++;
                n++;
            end
            tick();
        end
        get_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (put_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL full_while_read got %b want 0", put_ready[1]);
        end
        tick();
        get_ready = 1'b0;
        @(negedge clk);
        checks += 2;
        if (put_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_pop got %b want 1", put_ready[1]);
        end
        if (level[5:3] !== 3'd3) begin
            errors++;
            $display("FAIL level_after_pop got %0d want 3", level[5:3]);
        end
        sb1.push_back(v);
        tick();
        put_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (level[5:3] !== 3'd4) begin
            errors++;
            $display("FAIL level_refill got %0d want 4", level[5:3]);
        end
        get_ready = 1'b1;
        repeat (4) tick();
        get_ready = 1'b0;
        @(negedge clk);
        checks += 2;
        if (level[5:3] !== 3'd0) begin
            errors++;
            $display("FAIL level_drained got %0d want 0", level[5:3]);
        end
        if (get_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_drained got valid %b want 0", get_valid);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [CW-1:0] ec;
        get_ready = 1'b0;
        put_valid = 2'b11;
        put_data  = 16'hB0A0;
        sb0.push_back(8'hA0);
        sb1.push_back(8'hB0);
        tick();
        put_data = 16'hB1A1;
        sb0.push_back(8'hA1);
        sb1.push_back(8'hB1);
        tick();
        put_valid = 2'b00;
        get_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ec = i[0];
            @(negedge clk);
            checks++;
            if (get_chan !== ec) begin
                errors++;
                $display("FAIL rr_order i=%0d got chan %0d want %0d", i, get_chan, ec);
            end
            tick();
        end
        get_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (get_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_drained got valid %b want 0", get_valid);
        end
        tick();
    endtask

    task automatic lock_case(input logic [7:0] held_word, input logic [7:0] late_word);
        get_ready = 1'b0;
        put_valid = 2'b10;
        put_data  = {held_word, 8'h00};
        sb1.push_back(held_word);
        tick();
        put_valid = 2'b01;
        put_data  = {8'h00, late_word};
        sb0.push_back(late_word);
        tick();
        put_valid = 2'b00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (get_chan !== 1'b1 || get_data !== held_word) begin
                errors++;
                $display("FAIL lock_hold c=%0d got chan %0d data %h want 1 %h",
                         c, get_chan, get_data, held_word);
            end
            tick();
        end
        get_ready = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (get_chan !== 1'b0 || get_data !== late_word) begin
            errors++;
            $display("FAIL lock_next got chan %0d data %h want 0 %h", get_chan, get_data, late_word);
        end
        tick();
        get_ready = 1'b0;
    endtask

    task automatic test_grant_lock();
        // rr_ptr is 0 here, so ch0 would win without the lock.
        lock_case(8'h66, 8'h33);
        // rr_ptr is now 1 after the ch0 transfer.
        lock_case(8'h55, 8'h22);
    endtask

    task automatic test_reset_mid_burst();
        get_ready = 1'b0;
        put_valid = 2'b01;
        for (int c = 1; c <= 3; c++) begin
            put_data[7:0] = 8'(c);
            sb0.push_back(8'(c));
            tick();
        end
        put_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (level[2:0] !== 3'd3) begin
            errors++;
            $display("FAIL burst_level got %0d want 3", level[2:0]);
        end
        tick();
        reset         = 1'b1;
        put_valid     = 2'b01;
        put_data[7:0] = 8'hEE;
        sb0.delete();
        tick();
        reset     = 1'b0;
        put_valid = 2'b00;
        get_ready = 1'b1;
        @(negedge clk);
        checks += 3;
        if (level !== '0) begin
            errors++;
            $display("FAIL mid_reset_level got %h want 0", level);
        end
        if (get_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_valid got %b want 0", get_valid);
        end
        if (put_ready !== 2'b11) begin
            errors++;
            $display("FAIL mid_reset_ready got %b want 11", put_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if (get_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_word got valid %b data %h", get_valid, get_data);
        end
        put_valid     = 2'b01;
        put_data[7:0] = 8'h44;
        sb0.push_back(8'h44);
        tick();
        put_valid = 2'b00;
        @(negedge clk);
        checks++;
        if (get_valid !== 1'b1 || get_chan !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_word got valid %b chan %0d want 1 0", get_valid, get_chan);
        end
        tick();
        get_ready = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_tog   = 1'b0;
        reset     = 1'b1;
        put_valid = '0;
        put_data  = '0;
        get_ready = 1'b0;
        test_reset();
        test_single();
        test_fill_wrap();
        test_round_robin();
        test_grant_lock();
        test_reset_mid_burst();
        repeat (2) tick();
        checks++;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            errors++;
            $display("FAIL leftover got %0d/%0d words want 0/0", sb0.size(), sb1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
